// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that serialises one NREQ-way parallel word per frame, MSB first, with a strobe.
// Latency: gnt and the first bit appear one edge after arbitration; done follows WIDTH edges after capture.
// Backpressure: requesters hold req/data until gnt; no request is seen during SHIFT or GAP except at the arbitration edge.
module serial_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 7,
  parameter int GAP   = 1,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_flat,
  output logic [NREQ-1:0]       gnt,
  output logic                  data_line,
  output logic                  strobe,
  output logic [IDW-1:0]        src_id,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [3:0]        gcnt_q, gcnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              line_q, line_d;
  logic              strobe_q, strobe_d;
  logic [IDW-1:0]    src_q, src_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              win_vld;
  logic [IDW-1:0]    win_idx;
  logic [IDW:0]      cand;
  logic [WIDTH-1:0]  win_word;
  logic              arb;

  // Round-robin search starting one past the last granted index, wrapping modulo NREQ
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!win_vld && req[cand[IDW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IDW-1:0];
      end
    end
  end

  assign win_word = data_flat[win_idx*WIDTH +: WIDTH];

  // Next-state and output decode; a successful arbitration overrides the per-state defaults
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sh_d     = sh_q;
    bcnt_d   = bcnt_q;
    gcnt_d   = gcnt_q;
    gnt_d    = '0;
    line_d   = line_q;
    strobe_d = strobe_q;
    src_d    = src_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    arb      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        arb = 1'b1;
      end
      ST_SHIFT: begin
        if (bcnt_q != BW'(WIDTH)) begin
          line_d = sh_q[WIDTH-2];
          sh_d   = sh_q << 1;
          bcnt_d = bcnt_q + BW'(1);
        end else begin
          // LSB has been on the line for a full cycle: frame complete
          done_d   = 1'b1;
          strobe_d = 1'b0;
          line_d   = 1'b0;
          if (GAP > 0) begin
            gcnt_d  = '0;
            state_d = ST_GAP;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            arb     = 1'b1;
          end
        end
      end
      ST_GAP: begin
        gcnt_d = gcnt_q + 4'd1;
        if (gcnt_q == 4'(GAP - 1)) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          arb     = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (arb && win_vld) begin
      sh_d         = win_word;
      gnt_d[win_idx] = 1'b1;
      ptr_d        = win_idx;
      src_d        = win_idx;
      busy_d       = 1'b1;
      line_d       = win_word[WIDTH-1];
      strobe_d     = 1'b1;
      bcnt_d       = BW'(1);
      state_d      = ST_SHIFT;
    end
  end

  // State and output registers; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= IDW'(NREQ - 1);
      sh_q     <= '0;
      bcnt_q   <= '0;
      gcnt_q   <= '0;
      gnt_q    <= '0;
      line_q   <= 1'b0;
      strobe_q <= 1'b0;
      src_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sh_q     <= sh_d;
      bcnt_q   <= bcnt_d;
      gcnt_q   <= gcnt_d;
      gnt_q    <= gnt_d;
      line_q   <= line_d;
      strobe_q <= strobe_d;
      src_q    <= src_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign gnt       = gnt_q;
  assign data_line = line_q;
  assign strobe    = strobe_q;
  assign src_id    = src_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: one GAP=1 instance and one GAP=0 instance.
// A timeline model predicts grant cycles and words; a negedge monitor compares every output.
// Directed scenarios first, then randomized requesters that hold req until granted.
module tb_serial_tx_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 7;

  typedef struct {
    int             cyc;
    int             id;
    logic [W-1:0]   word;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]   req_v  [2];
  logic [NREQ*W-1:0] dat_v  [2];
  logic [NREQ-1:0]   gnt_v  [2];
  logic              line_v [2];
  logic              strb_v [2];
  logic [1:0]        src_v  [2];
  logic              busy_v [2];
  logic              done_v [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  frame_t q0[$];
  frame_t q1[$];
  int ptr_m[2], nxt_m[2], cap_m[2], pcap_m[2], src_m[2];

  // monitor state and logs
  int bitk[2], run[2], last_run[2], glog_n[2], rx_n[2], rx_total[2], gnt_total[2];
  logic [W-1:0] cur_word[2];
  logic [W-1:0] rxw[2];
  int glog_id[2][64];
  int glog_cyc[2][64];
  logic [W-1:0] rxlog[2][64];

  serial_tx_arbiter #(.NREQ(NREQ), .WIDTH(W), .GAP(1)) dut_g1 (
    .clk(clk), .rst(rst), .req(req_v[0]), .data_flat(dat_v[0]), .gnt(gnt_v[0]),
    .data_line(line_v[0]), .strobe(strb_v[0]), .src_id(src_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  serial_tx_arbiter #(.NREQ(NREQ), .WIDTH(W), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .req(req_v[1]), .data_flat(dat_v[1]), .gnt(gnt_v[1]),
    .data_line(line_v[1]), .strobe(strb_v[1]), .src_id(src_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the line is free for a new arbitration WIDTH+GAP cycles after a capture,
  // every cycle otherwise; the winner is the first raised req after the last granted index.
  task automatic model(input int u);
    int g;
    int w;
    frame_t f;
    g = (u == 0) ? 1 : 0;
    if (!rst) begin
      ptr_m[u]  = NREQ - 1;
      nxt_m[u]  = cyc + 1;
      cap_m[u]  = -1000;
      pcap_m[u] = -1000;
      src_m[u]  = 0;
      if (u == 0) q0.delete(); else q1.delete();
    end else if (cyc >= nxt_m[u]) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (ptr_m[u] + k) % NREQ;
        if (w < 0 && req_v[u][i]) w = i;
      end
      if (w >= 0) begin
        f.cyc  = cyc;
        f.id   = w;
        f.word = dat_v[u][w*W +: W];
        if (u == 0) q0.push_back(f); else q1.push_back(f);
        ptr_m[u]  = w;
        pcap_m[u] = cap_m[u];
        cap_m[u]  = cyc;
        src_m[u]  = w;
        nxt_m[u]  = cyc + W + g;
      end else begin
        nxt_m[u] = cyc + 1;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    model(0);
    model(1);
  end

  task automatic mon(input int u);
    int g;
    bit es, eb, ed, have;
    frame_t f;
    string s;
    g = (u == 0) ? 1 : 0;
    s = $sformatf("u%0d", u);
    if (!rst) begin
      check({s, "_reset_outputs"},
            int'({gnt_v[u], line_v[u], strb_v[u], busy_v[u], done_v[u], src_v[u]}), 0);
      bitk[u] = 0;
      run[u]  = 0;
      return;
    end
    es = (cyc >= cap_m[u]) && (cyc < cap_m[u] + W);
    eb = (cyc >= cap_m[u]) && (cyc < cap_m[u] + W + g);
    ed = (cyc == cap_m[u] + W) || (cyc == pcap_m[u] + W);

    if (gnt_v[u] != '0 || cyc == cap_m[u]) begin
      have = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
      check({s, "_grant_expected"}, int'(have), 1);
      if (have) begin
        if (u == 0) f = q0.pop_front(); else f = q1.pop_front();
        check({s, "_grant_cycle"}, cyc, f.cyc);
        check({s, "_gnt_onehot"}, int'(gnt_v[u]), 1 << f.id);
        cur_word[u] = f.word;
        bitk[u] = 0;
        rxw[u]  = '0;
        gnt_total[u]++;
        if (glog_n[u] < 64) begin
          glog_id[u][glog_n[u]]  = int'(src_v[u]);
          glog_cyc[u][glog_n[u]] = cyc;
          glog_n[u]++;
        end
      end
    end else begin
      check({s, "_gnt_idle"}, int'(gnt_v[u]), 0);
    end

    check({s, "_strobe"}, int'(strb_v[u]), int'(es));
    check({s, "_busy"}, int'(busy_v[u]), int'(eb));
    check({s, "_done"}, int'(done_v[u]), int'(ed));
    check({s, "_src_id"}, int'(src_v[u]), src_m[u]);

    if (es && strb_v[u] && bitk[u] < W) begin
      check({s, "_data_bit"}, int'(line_v[u]), int'(cur_word[u][W-1-bitk[u]]));
      rxw[u] = {rxw[u][W-2:0], line_v[u]};
      bitk[u]++;
      if (bitk[u] == W) begin
        rx_total[u]++;
        if (rx_n[u] < 64) begin
          rxlog[u][rx_n[u]] = rxw[u];
          rx_n[u]++;
        end
      end
    end

    if (strb_v[u]) begin
      run[u]++;
    end else begin
      if (run[u] > 0) last_run[u] = run[u];
      run[u] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    for (int u = 0; u < 2; u++) begin
      glog_n[u] = 0;
      rx_n[u]   = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_v[0] = '0;
    req_v[1] = '0;
    tick();
    tick();
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic wait_gnt(input int u, input int i);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      tick();
      if (gnt_v[u][i]) ok = 1'b1;
    end
    check($sformatf("u%0d_wait_gnt%0d_timeout", u, i), int'(ok), 1);
  endtask

  // Drop each request of instance u as soon as it is granted; bounded
  task automatic drain_on_gnt(input int u);
    for (int n = 0; n < 80 && req_v[u] != '0; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_v[u][i]) req_v[u][i] = 1'b0;
      end
    end
    check($sformatf("u%0d_drain_timeout", u), int'(req_v[u]), 0);
  endtask

  initial begin
    int exp2[5];
    rst = 1'b0;
    req_v[0] = '0;
    req_v[1] = '0;
    dat_v[0] = '0;
    dat_v[1] = '0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d_init_strobe", u), int'(strb_v[u]), 0);
      check($sformatf("u%0d_init_line", u), int'(line_v[u]), 0);
      check($sformatf("u%0d_init_gnt", u), int'(gnt_v[u]), 0);
      check($sformatf("u%0d_init_busy", u), int'(busy_v[u]), 0);
      check($sformatf("u%0d_init_done", u), int'(done_v[u]), 0);
      check($sformatf("u%0d_init_src", u), int'(src_v[u]), 0);
    end
    tick();
    rst = 1'b1;
    clear_logs();

    // single word from requester 0
    dat_v[0][0 +: W] = 7'b1011001;
    req_v[0] = 4'b0001;
    wait_gnt(0, 0);
    req_v[0] = '0;
    repeat (12) tick();
    check("t1_frames", rx_n[0], 1);
    check("t1_word", int'(rxlog[0][0]), int'(7'b1011001));
    check("t1_src", int'(src_v[0]), 0);
    check("t1_busy_after", int'(busy_v[0]), 0);

    // all four requesting: rotation 0,1,2,3,0
    do_reset();
    dat_v[0] = {7'h44, 7'h33, 7'h22, 7'h11};
    req_v[0] = 4'b1111;
    for (int n = 0; n < 60 && glog_n[0] < 5; n++) tick();
    req_v[0] = '0;
    repeat (12) tick();
    exp2 = '{0, 1, 2, 3, 0};
    check("t2_count", glog_n[0], 5);
    for (int k = 0; k < 5; k++) check($sformatf("t2_order%0d", k), glog_id[0][k], exp2[k]);

    // lone requester 2: back-to-back every WIDTH+GAP cycles
    do_reset();
    dat_v[0][2*W +: W] = 7'h5a;
    req_v[0] = 4'b0100;
    for (int n = 0; n < 60 && glog_n[0] < 3; n++) tick();
    req_v[0] = '0;
    repeat (12) tick();
    check("t3_count", glog_n[0], 3);
    for (int k = 0; k < 3; k++) check($sformatf("t3_id%0d", k), glog_id[0][k], 2);
    check("t3_period_a", glog_cyc[0][1] - glog_cyc[0][0], 8);
    check("t3_period_b", glog_cyc[0][2] - glog_cyc[0][1], 8);

    // GAP=0: two frames with no strobe-low cycle between them
    do_reset();
    dat_v[1][0 +: W] = 7'h2b;
    dat_v[1][W +: W] = 7'h64;
    req_v[1] = 4'b0011;
    drain_on_gnt(1);
    repeat (12) tick();
    check("t4_strobe_run", last_run[1], 14);
    check("t4_frames", rx_n[1], 2);
    check("t4_first", glog_id[1][0], 0);
    check("t4_second", glog_id[1][1], 1);

    // reset while bit 4 is on the line
    do_reset();
    dat_v[0][0 +: W] = 7'h4d;
    req_v[0] = 4'b0001;
    wait_gnt(0, 0);
    req_v[0] = '0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check("t5_line", int'(line_v[0]), 0);
    check("t5_strobe", int'(strb_v[0]), 0);
    check("t5_busy", int'(busy_v[0]), 0);
    check("t5_done", int'(done_v[0]), 0);
    check("t5_src", int'(src_v[0]), 0);
    tick();
    tick();
    clear_logs();
    dat_v[0][0 +: W] = 7'h0f;
    dat_v[0][W +: W] = 7'h70;
    req_v[0] = 4'b0011;
    rst = 1'b1;
    drain_on_gnt(0);
    repeat (12) tick();
    check("t5_first_after_reset", glog_id[0][0], 0);
    check("t5_frames_after_reset", rx_n[0], 2);

    // request pulsed only during SHIFT is never seen
    do_reset();
    dat_v[0][0 +: W] = 7'h33;
    req_v[0] = 4'b0001;
    wait_gnt(0, 0);
    req_v[0] = '0;
    tick();
    tick();
    req_v[0][3] = 1'b1;
    tick();
    tick();
    req_v[0][3] = 1'b0;
    repeat (12) tick();
    check("t6_grants", glog_n[0], 1);
    check("t6_busy", int'(busy_v[0]), 0);

    // randomized requesters on both instances
    do_reset();
    for (int u = 0; u < 2; u++) begin
      rx_total[u]  = 0;
      gnt_total[u] = 0;
    end
    for (int n = 0; n < 2000; n++) begin
      tick();
      for (int u = 0; u < 2; u++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_v[u][i]) begin
            if (gnt_v[u][i]) begin
              if ($urandom_range(1, 0) == 1) dat_v[u][i*W +: W] = W'($urandom);
              else req_v[u][i] = 1'b0;
            end
          end else if ($urandom_range(7, 0) == 0) begin
            req_v[u][i] = 1'b1;
            dat_v[u][i*W +: W] = W'($urandom);
          end
        end
      end
    end
    drain_on_gnt(0);
    drain_on_gnt(1);
    repeat (20) tick();
    for (int u = 0; u < 2; u++) begin
      check($sformatf("rand_u%0d_frames", u), rx_total[u], gnt_total[u]);
      check($sformatf("rand_u%0d_busy_end", u), int'(busy_v[u]), 0);
    end
    check("rand_u0_sb_empty", q0.size(), 0);
    check("rand_u1_sb_empty", q1.size(), 0);
    check("rand_u0_activity", int'(gnt_total[0] > 50), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
